// File: rtl/beep_pkg.sv
// rtl/beep_pkg.sv - shared widths, envelope state type and sample arithmetic
// for the beeper mixer.
package beep_pkg;

  localparam int GAIN_W  = 8;
  localparam int VOL_W   = 4;
  localparam int AUDIO_W = 16;
  localparam int MAG_W   = GAIN_W + VOL_W + 3;

  localparam logic [GAIN_W-1:0] GAIN_MAX = '1;

  typedef enum logic [1:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_e;

  // (gain * volume) << 3 tops out at 30600, so it never reaches the sign bit.
  function automatic logic [AUDIO_W-1:0] mix_sample(
    input logic [GAIN_W-1:0] gain,
    input logic [VOL_W-1:0]  vol,
    input logic              spk,
    input logic              idle
  );
    logic [GAIN_W+VOL_W-1:0] prod;
    logic [MAG_W-1:0]        mag;
    logic [AUDIO_W-1:0]      mag_ext;
    logic [AUDIO_W-1:0]      res;
    prod    = (GAIN_W+VOL_W)'(gain) * (GAIN_W+VOL_W)'(vol);
    mag     = {prod, 3'b000};
    mag_ext = {1'b0, mag};
    if (idle || (vol == '0)) begin
      res = '0;
    end else if (spk) begin
      res = mag_ext;
    end else begin
      res = -mag_ext;
    end
    return res;
  endfunction

endpackage

// File: rtl/beep_mixer_if.sv
// rtl/beep_mixer_if.sv - beeper control bundle: clock enable, square wave,
// on/off level and volume.
interface beep_mixer_if;
  import beep_pkg::*;

  logic             ce;
  logic             speaker;
  logic             beep_en;
  logic [VOL_W-1:0] volume;

  modport master (output ce, speaker, beep_en, volume);
  modport slave  (input  ce, speaker, beep_en, volume);

endinterface

// File: rtl/beep_env.sv
// rtl/beep_env.sv - attack/sustain/release envelope: gain ramps one step per
// RAMP_DIV ce ticks and saturates at 0 and full scale.
module beep_env
  import beep_pkg::*;
#(
  parameter int RAMP_DIV = 250
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  beep_mixer_if.slave       ctl,
  output logic [GAIN_W-1:0] gain_o,
  output logic              idle_o
);

  localparam int RCW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RCW-1:0] RAMP_LAST = RCW'(RAMP_DIV - 1);

  env_state_e        state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [RCW-1:0]    ramp_q, ramp_d;
  logic              ramp_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ENV_IDLE;
      gain_q  <= '0;
      ramp_q  <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      ramp_q  <= ramp_d;
    end
  end

  // Any state change restarts the ramp counter; beep_en edges take priority
  // over a pending gain step.
  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    ramp_d   = ramp_q;
    ramp_hit = (ramp_q == RAMP_LAST);
    if (ctl.ce) begin
      case (state_q)
        ENV_IDLE: begin
          gain_d = '0;
          if (ctl.beep_en) begin
            state_d = ENV_ATTACK;
            ramp_d  = '0;
          end
        end
        ENV_ATTACK: begin
          if (!ctl.beep_en) begin
            state_d = ENV_RELEASE;
            ramp_d  = '0;
          end else if (gain_q == GAIN_MAX) begin
            state_d = ENV_SUSTAIN;
            ramp_d  = '0;
          end else if (ramp_hit) begin
            ramp_d = '0;
            gain_d = gain_q + GAIN_W'(1);
            if (gain_q == (GAIN_MAX - GAIN_W'(1))) state_d = ENV_SUSTAIN;
          end else begin
            ramp_d = ramp_q + RCW'(1);
          end
        end
        ENV_SUSTAIN: begin
          gain_d = GAIN_MAX;
          if (!ctl.beep_en) begin
            state_d = ENV_RELEASE;
            ramp_d  = '0;
          end
        end
        ENV_RELEASE: begin
          if (ctl.beep_en) begin
            state_d = ENV_ATTACK;
            ramp_d  = '0;
          end else if (gain_q == '0) begin
            state_d = ENV_IDLE;
            ramp_d  = '0;
          end else if (ramp_hit) begin
            ramp_d = '0;
            gain_d = gain_q - GAIN_W'(1);
            if (gain_q == GAIN_W'(1)) state_d = ENV_IDLE;
          end else begin
            ramp_d = ramp_q + RCW'(1);
          end
        end
        default: begin
          state_d = ENV_IDLE;
          gain_d  = '0;
          ramp_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    gain_o = gain_q;
    idle_o = (state_q == ENV_IDLE);
  end

endmodule

// File: rtl/beep_mixer.sv
// rtl/beep_mixer.sv - turns the bleeper square wave into enveloped signed PCM
// at SAMPLE_DIV ce ticks per sample, identical on both channels.
module beep_mixer
  import beep_pkg::*;
#(
  parameter int SAMPLE_DIV = 1333,
  parameter int RAMP_DIV   = 250
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               ce,
  input  logic               speaker,
  input  logic               beep_en,
  input  logic [VOL_W-1:0]   volume,
  output logic [AUDIO_W-1:0] audio_l,
  output logic [AUDIO_W-1:0] audio_r,
  output logic               sample_stb
);

  localparam int SCW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLE_DIV - 1);

  beep_mixer_if ctl ();

  assign ctl.ce      = ce;
  assign ctl.speaker = speaker;
  assign ctl.beep_en = beep_en;
  assign ctl.volume  = volume;

  logic [GAIN_W-1:0]  gain;
  logic               idle;
  logic [SCW-1:0]     scnt_q, scnt_d;
  logic [AUDIO_W-1:0] audio_q, audio_d;
  logic               stb_q, stb_d;
  logic               trigger;

  beep_env #(
    .RAMP_DIV (RAMP_DIV)
  ) u_env (
    .clk_i  (clk_sys),
    .rst_ni (reset_n),
    .ctl    (ctl),
    .gain_o (gain),
    .idle_o (idle)
  );

  // The envelope register still holds its pre-step value on the trigger
  // tick, so a coincident gain step lands in the following sample.
  always_comb begin
    trigger = ctl.ce && (scnt_q == SAMPLE_LAST);
    scnt_d  = scnt_q;
    if (ctl.ce) scnt_d = trigger ? '0 : scnt_q + SCW'(1);
    stb_d   = trigger;
    audio_d = trigger ? mix_sample(gain, ctl.volume, ctl.speaker, idle) : audio_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      scnt_q  <= '0;
      audio_q <= '0;
      stb_q   <= 1'b0;
    end else begin
      scnt_q  <= scnt_d;
      audio_q <= audio_d;
      stb_q   <= stb_d;
    end
  end

  assign audio_l    = audio_q;
  assign audio_r    = audio_q;
  assign sample_stb = stb_q;

endmodule

// File: tb/tb_beep_mixer.sv
// tb/tb_beep_mixer.sv - scoreboard bench for beep_mixer with SAMPLE_DIV=4,
// RAMP_DIV=2.
module tb_beep_mixer;

  localparam int SD = 4;
  localparam int RD = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] audio_l, audio_r;
  logic        sample_stb;

  beep_mixer_if bus ();

  beep_mixer #(
    .SAMPLE_DIV (SD),
    .RAMP_DIV   (RD)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ce         (bus.ce),
    .speaker    (bus.speaker),
    .beep_en    (bus.beep_en),
    .volume     (bus.volume),
    .audio_l    (audio_l),
    .audio_r    (audio_r),
    .sample_stb (sample_stb)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] val;
    int unsigned cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [15:0] hold_val = 16'h0;

  always @(negedge clk_sys) begin : monitor
    exp_t e;
    if (!reset_n) begin
      hold_val = 16'h0;
    end else if (sample_stb) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got strobe expected none (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        check("audio_l", {16'h0, audio_l}, {16'h0, e.val});
        check("audio_r", {16'h0, audio_r}, {16'h0, e.val});
        check("strobe_cycle", e.cyc, cyc);
        hold_val = e.val;
      end
    end else begin
      check("audio_hold", {16'h0, audio_l}, {16'h0, hold_val});
    end
  end

  // Envelope expectation: piecewise-linear gain from the start of the current
  // ramp direction, one step per RD ticks, clamped to 0..255.
  int unsigned t;
  int          m_scnt;
  bit          m_be;
  bit          ph_att;
  int          ph_start;
  int          ph_g0;

  function automatic int gain_at(input int unsigned tt);
    int g;
    int d;
    d = int'(tt) - ph_start;
    if (ph_att) begin
      g = ph_g0 + d / RD;
      if (g > 255) g = 255;
    end else begin
      g = ph_g0 - d / RD;
      if (g < 0) g = 0;
    end
    return g;
  endfunction

  task automatic reset_model();
    t        = 0;
    m_scnt   = 0;
    m_be     = 1'b0;
    ph_att   = 1'b0;
    ph_start = 0;
    ph_g0    = 0;
  endtask

  task automatic step(input bit ce_v, input bit be, input bit spk, input logic [3:0] vol);
    int   g;
    int   mag;
    exp_t e;
    bus.ce      = ce_v;
    bus.beep_en = be;
    bus.speaker = spk;
    bus.volume  = vol;
    if (ce_v) begin
      g = gain_at(t);
      if (m_scnt == SD - 1) begin
        mag   = g * int'(vol) * 8;
        e.val = spk ? 16'(mag) : 16'(-mag);
        e.cyc = cyc + 1;
        sbq.push_back(e);
        m_scnt = 0;
      end else begin
        m_scnt++;
      end
      if (be != m_be) begin
        ph_att   = be;
        ph_start = int'(t) + 1;
        ph_g0    = g;
        m_be     = be;
      end
      t++;
    end
    @(negedge clk_sys);
  endtask

  initial begin
    int guard;
    bus.ce      = 1'b0;
    bus.beep_en = 1'b0;
    bus.speaker = 1'b0;
    bus.volume  = 4'd15;
    reset_model();
    repeat (3) @(negedge clk_sys);
    check("reset_audio_l", {16'h0, audio_l}, 32'h0);
    check("reset_audio_r", {16'h0, audio_r}, 32'h0);
    check("reset_stb", {31'h0, sample_stb}, 32'h0);
    reset_n = 1'b1;

    // Beeper off: strobes every SD clocks, silence regardless of speaker.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, i[0], 4'd15);

    // Full attack into sustain.
    for (int i = 0; i < 600; i++) step(1'b1, 1'b1, 1'b1, 4'd15);
    #1 check("sustain_pos", {16'h0, audio_l}, 32'h7788);

    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 4'd15);
    #1 check("sustain_neg", {16'h0, audio_l}, 32'h8878);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, i[0], 4'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 4'd7);
    // Speaker low except on trigger ticks: only the trigger value matters.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, (m_scnt == SD - 1), 4'd15);

    // Full release back to idle.
    for (int i = 0; i < 600; i++) step(1'b1, 1'b0, 1'b1, 4'd15);

    // Attack to 100, release to 40, re-attack.
    guard = 0;
    while (gain_at(t) != 100 && guard < 1000) begin
      step(1'b1, 1'b1, 1'b1, 4'd15);
      guard++;
    end
    check("bound_gain_100", {31'h0, guard < 1000}, 32'h1);
    guard = 0;
    while (gain_at(t) != 40 && guard < 1000) begin
      step(1'b1, 1'b0, 1'b1, 4'd15);
      guard++;
    end
    check("bound_gain_40", {31'h0, guard < 1000}, 32'h1);
    for (int i = 0; i < 41; i++) step(1'b1, 1'b1, 1'b1, 4'd15);

    // ce held low mid-attack: nothing moves.
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, i[0], 4'd15);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 4'd15);

    // Reach sustain, then pulse reset between clock edges.
    for (int i = 0; i < 500; i++) step(1'b1, 1'b1, 1'b1, 4'd15);
    #1 check("pre_reset_level", {16'h0, audio_l}, 32'h7788);
    bus.ce = 1'b0;
    @(posedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_l", {16'h0, audio_l}, 32'h0);
    check("async_reset_r", {16'h0, audio_r}, 32'h0);
    check("async_reset_stb", {31'h0, sample_stb}, 32'h0);
    @(negedge clk_sys);
    reset_model();
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b1, 4'd15);

    repeat (3) step(1'b0, 1'b1, 1'b1, 4'd15);
    check("queue_drained", sbq.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/beep_mixer.md
BEEP_MIXER -- requirements
Module: beep_mixer

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 1333, meaning ce ticks per output sample (64 MHz / 48 kHz).
REQ-002 SHALL have parameter RAMP_DIV, default 250, meaning ce ticks per envelope gain step (255 steps, about 1 ms full ramp).
REQ-003 SHALL have port clk_sys, input, 1 bit: the single system clock.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port ce, input, 1 bit: clock enable, the same strobe that drives the bleeper square-wave generator.
REQ-006 SHALL have port speaker, input, 1 bit: square wave from the bleeper.
REQ-007 SHALL have port beep_en, input, 1 bit: beeper on/off level decoded from port F8 (1 = on).
REQ-008 SHALL have port volume, input, 4 bits: unsigned output gain; 0 = mute.
REQ-009 SHALL have port audio_l, output, 16 bits: signed PCM, left channel.
REQ-010 SHALL have port audio_r, output, 16 bits: signed PCM, right channel, always equal to audio_l.
REQ-011 SHALL have port sample_stb, output, 1 bit: one-clk_sys pulse on each new sample.

Function
REQ-012 SHALL do nothing on cycles where ce=0: all counters and state hold, and sample_stb=0.
REQ-013 SHALL keep an 8-bit gain under an envelope FSM with states IDLE, ATTACK, SUSTAIN and RELEASE.
REQ-014 IDLE: gain=0; beep_en=1 moves the FSM to ATTACK.
REQ-015 ATTACK: gain+1 every RAMP_DIV ce ticks; at gain=255 move to SUSTAIN; beep_en=0 moves to RELEASE and keeps the current gain.
REQ-016 SUSTAIN: gain=255; beep_en=0 moves to RELEASE.
REQ-017 RELEASE: gain-1 every RAMP_DIV ce ticks; at gain=0 move to IDLE; beep_en=1 moves to ATTACK and keeps the current gain.
REQ-018 SHALL restart the ramp-tick counter at 0 on every FSM state change.
REQ-019 SHALL never wrap gain: it saturates at 0 and 255.
REQ-020 SHALL run a sample counter 0..SAMPLE_DIV-1 on ce ticks; on the tick where it reaches SAMPLE_DIV-1 it wraps to 0 and triggers a sample.
REQ-021 At the sample trigger, SHALL compute mag = (gain * volume) << 3 as a 15-bit unsigned value (maximum 30600, no overflow).
REQ-022 SHALL set sample = +mag when speaker=1 and -mag when speaker=0, in two's complement, 16 bits.
REQ-023 SHALL set sample = 0 whenever the FSM is IDLE or volume=0, regardless of speaker.
REQ-024 SHALL register audio_l, audio_r and sample_stb so they appear 1 clk_sys cycle after the trigger cycle; audio outputs hold between strobes.
REQ-025 SHALL sample speaker, gain and volume only on the trigger cycle; changes between strobes have no effect on the outputs.
REQ-026 When a gain step and a sample trigger occur on the same tick, SHALL use the pre-step gain in that sample.

Reset
REQ-027 SHALL on reset_n=0, asynchronously: FSM=IDLE, gain=0, all counters=0, audio_l=audio_r=0, sample_stb=0.
REQ-028 SHALL on reset mid-ramp drop output to 0 immediately with no ramp-down; after release, resume from IDLE.

Structure
REQ-029 SHALL place the FSM state enum, GAIN_W=8, VOL_W=4 and AUDIO_W=16 in package beep_pkg.
REQ-030 SHALL implement the envelope FSM, gain register and ramp counter in sub-module beep_env (outputs gain and idle); beep_mixer holds the sample counter and output arithmetic.
REQ-031 SHALL make all arithmetic explicitly sized; no truncation of mag is permitted.

Verification (SAMPLE_DIV=4, RAMP_DIV=2, ce=1)
REQ-032 Reset, beep_en=0, volume=15, speaker toggling -> sample_stb every 4 clocks; audio_l=audio_r=0 throughout.
REQ-033 beep_en 0->1, volume=15, speaker=1 -> gain rises 1 per 2 clocks; SUSTAIN reached after 510 clocks; audio_l then steady at +30600 (0x7788).
REQ-034 In SUSTAIN, speaker=0 -> next sample is -30600 (0x8878); volume=0 -> next sample is 0.
REQ-035 beep_en=1 until gain=100, then beep_en=0 -> RELEASE starts from 100 and reaches IDLE after 200 clocks; a re-assert at gain=40 returns to ATTACK from 40.
REQ-036 ce held 0 for 50 clocks mid-ATTACK -> gain, counters and outputs frozen; no sample_stb.
REQ-037 reset_n pulsed low mid-SUSTAIN, asynchronous to clk_sys -> outputs 0 within the same cycle; after release the ramp restarts from gain 0.
